// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory responder: default geometry,
// controller state encoding and the byte-strobe merge helper.
package cpu_mem_pkg;

    localparam int unsigned DataWidth    = 32;
    localparam int unsigned AddrWidth    = 32;
    localparam int unsigned MemDepthLog2 = 12;
    localparam int unsigned WordSize     = 4;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Replace the strobed bytes of old_w with those of new_w.
    function automatic logic [DataWidth-1:0] byte_merge(
        input logic [DataWidth-1:0] old_w,
        input logic [DataWidth-1:0] new_w,
        input logic [WordSize-1:0]  strb
    );
        logic [DataWidth-1:0] merged;
        merged = old_w;
        for (int i = 0; i < int'(WordSize); i++) begin
            if (strb[i]) merged[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_word_array.sv
// Word-organised storage: one byte-strobed write port and two registered
// read ports with write-first bypass. A per-port clear forces the read
// register to zero (used for out-of-range and not-ready gating).
module sram_word_array #(
    parameter int unsigned DataWidth = cpu_mem_pkg::DataWidth,
    parameter int unsigned WordSize  = cpu_mem_pkg::WordSize,
    parameter int unsigned IdxWidth  = cpu_mem_pkg::MemDepthLog2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WordSize-1:0]  we_i,
    input  logic [IdxWidth-1:0]  waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 a_re_i,
    input  logic                 a_clr_i,
    input  logic [IdxWidth-1:0]  a_addr_i,
    output logic [DataWidth-1:0] a_data_o,
    input  logic                 b_re_i,
    input  logic                 b_clr_i,
    input  logic [IdxWidth-1:0]  b_addr_i,
    output logic [DataWidth-1:0] b_data_o
);
    import cpu_mem_pkg::*;

    localparam int unsigned Depth = 1 << IdxWidth;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] a_data_q, b_data_q;
    logic [DataWidth-1:0] a_fwd_c, b_fwd_c;

    // Byte-strobed write into the array.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(WordSize); i++) begin
            if (we_i[i]) mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
    end

    // Write-first view of each read word (merge is a no-op when we_i is 0).
    always_comb begin
        a_fwd_c = mem_q[a_addr_i];
        b_fwd_c = mem_q[b_addr_i];
        if (waddr_i == a_addr_i) a_fwd_c = byte_merge(mem_q[a_addr_i], wdata_i, we_i);
        if (waddr_i == b_addr_i) b_fwd_c = byte_merge(mem_q[b_addr_i], wdata_i, we_i);
    end

    // Registered read data: clear wins, otherwise load on enable, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            if (a_clr_i)     a_data_q <= '0;
            else if (a_re_i) a_data_q <= a_fwd_c;
            if (b_clr_i)     b_data_q <= '0;
            else if (b_re_i) b_data_q <= b_fwd_c;
        end
    end

    assign a_data_o = a_data_q;
    assign b_data_o = b_data_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// CPU instruction/data memory responder: clear sequencer, range check,
// sticky address error and output gating around sram_word_array.
// Optional feature macro: MEM_CLEAR_EN (zero the array after every reset).
module cpu_mem_responder #(
    parameter int unsigned DataWidth    = cpu_mem_pkg::DataWidth,
    parameter int unsigned AddrWidth    = cpu_mem_pkg::AddrWidth,
    parameter int unsigned MemDepthLog2 = cpu_mem_pkg::MemDepthLog2,
    parameter int unsigned WordSize     = cpu_mem_pkg::WordSize
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_read,
    input  logic [AddrWidth-1:0] instr_addr,
    output logic [DataWidth-1:0] instr_out,
    input  logic                 data_read,
    input  logic [WordSize-1:0]  data_write,
    input  logic [AddrWidth-1:0] data_addr,
    input  logic [DataWidth-1:0] data_in,
    output logic [DataWidth-1:0] data_out,
    output logic                 mem_ready,
    output logic                 addr_err
);
    import cpu_mem_pkg::*;

    localparam int unsigned IdxWidth = MemDepthLog2;

    logic [IdxWidth-1:0]  instr_idx_c, data_idx_c, clr_idx_c, waddr_c;
    logic                 instr_oor_c, data_oor_c, active_c, ready_d;
    logic [WordSize-1:0]  we_c;
    logic [DataWidth-1:0] wdata_c;
    logic                 err_q, err_d, ready_q;
    logic                 unused_addr_lsb;

    assign instr_idx_c     = instr_addr[IdxWidth+1:2];
    assign data_idx_c      = data_addr[IdxWidth+1:2];
    assign instr_oor_c     = |instr_addr[AddrWidth-1:IdxWidth+2];
    assign data_oor_c      = |data_addr[AddrWidth-1:IdxWidth+2];
    assign unused_addr_lsb = ^{instr_addr[1:0], data_addr[1:0]};

`ifdef MEM_CLEAR_EN
    state_e              state_q, state_d;
    logic [IdxWidth-1:0] cnt_q, cnt_d;

    // Clear sequencer: walk every word once, then serve the CPU.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == '1) state_d = ST_READY;
                else             cnt_d   = cnt_q + IdxWidth'(1);
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // Sequencer state and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign active_c  = (state_q == ST_READY);
    assign clr_idx_c = cnt_q;
    assign ready_d   = (state_d == ST_READY);
`else
    assign active_c  = 1'b1;
    assign clr_idx_c = '0;
    assign ready_d   = 1'b1;
`endif

    // Write port: clearing sequence owns it, else in-range CPU stores.
    always_comb begin
        we_c    = '0;
        waddr_c = data_idx_c;
        wdata_c = data_in;
        if (!active_c) begin
            we_c    = '1;
            waddr_c = clr_idx_c;
            wdata_c = '0;
        end else if (!data_oor_c) begin
            we_c = data_write;
        end
    end

    // Sticky error on any enabled out-of-range access.
    always_comb begin
        err_d = err_q;
        if (active_c && ((instr_read && instr_oor_c) ||
                         ((data_read || (|data_write)) && data_oor_c)))
            err_d = 1'b1;
    end

    // Error flag and ready indication registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    sram_word_array #(
        .DataWidth (DataWidth),
        .WordSize  (WordSize),
        .IdxWidth  (IdxWidth)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst),
        .we_i     (we_c),
        .waddr_i  (waddr_c),
        .wdata_i  (wdata_c),
        .a_re_i   (active_c && instr_read),
        .a_clr_i  (!active_c || (instr_read && instr_oor_c)),
        .a_addr_i (instr_idx_c),
        .a_data_o (instr_out),
        .b_re_i   (active_c && data_read),
        .b_clr_i  (!active_c || (data_read && data_oor_c)),
        .b_addr_i (data_idx_c),
        .b_data_o (data_out)
    );

    assign mem_ready = ready_q;
    assign addr_err  = err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: table of vectors with
// hand-derived expectations routed through a scoreboard queue, plus
// reset/ready-latency sequences. Honours MEM_CLEAR_EN when defined.
module tb_cpu_mem_responder;

`ifdef MEM_CLEAR_EN
    localparam int ReadyLat = 4096;
`else
    localparam int ReadyLat = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_read;
    logic [31:0] instr_addr;
    logic [31:0] instr_out;
    logic        data_read;
    logic [3:0]  data_write;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mem_ready;
    logic        addr_err;

    typedef struct {
        logic [3:0]  wr;
        logic [31:0] daddr;
        logic [31:0] din;
        logic        drd;
        logic        ird;
        logic [31:0] iaddr;
        logic [31:0] exp_d;
        logic [31:0] exp_i;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [31:0] i;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    vec_t tbl [14];
    vec_t zv  [2];

    always #5 clk = ~clk;

    cpu_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .instr_read (instr_read),
        .instr_addr (instr_addr),
        .instr_out  (instr_out),
        .data_read  (data_read),
        .data_write (data_write),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .mem_ready  (mem_ready),
        .addr_err   (addr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        instr_read = 1'b0;
        data_read  = 1'b0;
        data_write = 4'b0000;
        instr_addr = 32'h0;
        data_addr  = 32'h0;
        data_in    = 32'h0;
    endtask

    // Drive one vector for a cycle; its expectation goes through the queue.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        data_write = v.wr;
        data_addr  = v.daddr;
        data_in    = v.din;
        data_read  = v.drd;
        instr_read = v.ird;
        instr_addr = v.iaddr;
        exp_q.push_back('{d: v.exp_d, i: v.exp_i, err: v.exp_err});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, " data_out"},  data_out,         e.d);
        check({tag, " instr_out"}, instr_out,        e.i);
        check({tag, " addr_err"},  32'(addr_err),    32'(e.err));
    endtask

    // Count edges from reset release until mem_ready, with a bound.
    task automatic wait_ready(input int expect_n, input string name);
        int n;
        n = 0;
        while (n < 6000) begin
            @(posedge clk);
            #1;
            n++;
            if (mem_ready) break;
        end
        check(name, 32'(n), 32'(expect_n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //        wr       daddr          din            drd   ird   iaddr          exp_d          exp_i          err
        tbl[0]  = '{4'hF, 32'h0000_0000, 32'h55AA_55AA, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[1]  = '{4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[2]  = '{4'h0, 32'h0000_0010, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0013, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        tbl[3]  = '{4'hF, 32'h0000_0020, 32'h1122_3344, 1'b0, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        tbl[4]  = '{4'h5, 32'h0000_0020, 32'hAABB_CCDD, 1'b1, 1'b0, 32'h0000_0000, 32'h11BB_33DD, 32'hDEAD_BEEF, 1'b0};
        tbl[5]  = '{4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0022, 32'h11BB_33DD, 32'h11BB_33DD, 1'b0};
        tbl[6]  = '{4'hF, 32'h0000_0024, 32'h0BAD_F00D, 1'b0, 1'b1, 32'h0000_0024, 32'h11BB_33DD, 32'h0BAD_F00D, 1'b0};
        tbl[7]  = '{4'h0, 32'h0000_0024, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0010, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
        tbl[8]  = '{4'hF, 32'h0000_8000, 32'h1234_5678, 1'b0, 1'b0, 32'h0000_0004, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1};
        tbl[9]  = '{4'h0, 32'h0000_8000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h0BAD_F00D, 1'b1};
        tbl[10] = '{4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 32'h55AA_55AA, 32'h0BAD_F00D, 1'b1};
        tbl[11] = '{4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h55AA_55AA, 32'h0000_0000, 1'b1};
        tbl[12] = '{4'hF, 32'h0000_3FFC, 32'hA5A5_0001, 1'b0, 1'b1, 32'h0000_3FFC, 32'h55AA_55AA, 32'hA5A5_0001, 1'b1};
        tbl[13] = '{4'h0, 32'h0000_3FFD, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 32'hA5A5_0001, 32'hA5A5_0001, 1'b1};

        // Words 0, 2048 and 4095 read back as zero after a clear.
        zv[0]   = '{4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_2000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        zv[1]   = '{4'h0, 32'h0000_3FFC, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};

        idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset instr_out", instr_out, 32'h0);
        check("reset data_out",  data_out,  32'h0);
        check("reset mem_ready", 32'(mem_ready), 32'h0);
        check("reset addr_err",  32'(addr_err),  32'h0);

        @(negedge clk);
        rst = 1'b1;
        wait_ready(ReadyLat, "ready_latency");

`ifdef MEM_CLEAR_EN
        foreach (zv[k]) apply(zv[k], $sformatf("clear0_%0d", k));
`endif

        foreach (tbl[k]) apply(tbl[k], $sformatf("vec%0d", k));

        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        check("reset2 addr_err", 32'(addr_err), 32'h0);
        check("reset2 data_out", data_out, 32'h0);
        check("reset2 mem_ready", 32'(mem_ready), 32'h0);

`ifdef MEM_CLEAR_EN
        // Interrupt the clear at count 100; it must restart from word 0.
        @(negedge clk);
        rst = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wait_ready(4096, "ready_after_midclear_reset");
        foreach (zv[k]) apply(zv[k], $sformatf("clear1_%0d", k));
`else
        @(negedge clk);
        rst = 1'b1;
        wait_ready(1, "ready_after_reset2");
`endif
        check("addr_err after reset2", 32'(addr_err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
